// File: rtl/player_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : player_ctrl
//  Purpose  : Debounced button input, wall/border checked stepping and
//             registered player position with a redraw handshake.
//             Optional auto-repeat: define PLAYER_CTRL_AUTOREPEAT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module player_ctrl #(
    parameter int COLS            = 10,
    parameter int ROWS            = 15,
    parameter int CELL_PX         = 20,
    parameter int START_X         = 0,
    parameter int START_Y         = 0,
    parameter int GOAL_X          = 9,
    parameter int GOAL_Y          = 14,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic                       btn_left,
    input  logic                       btn_right,
    input  logic [(ROWS+1)*COLS-1:0]   h_walls,
    input  logic [ROWS*(COLS+1)-1:0]   v_walls,
    input  logic                       redraw_ack,
    output logic [3:0]                 cell_x,
    output logic [3:0]                 cell_y,
    output logic [8:0]                 pix_x,
    output logic [8:0]                 pix_y,
    output logic [3:0]                 prev_x,
    output logic [3:0]                 prev_y,
    output logic                       redraw,
    output logic                       bump,
    output logic                       at_goal
);

    localparam int              c_hw        = (ROWS + 1) * COLS;
    localparam int              c_vw        = ROWS * (COLS + 1);
    localparam int              c_db_w      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_hw-1:0] c_h_one     = c_hw'(1);
    localparam logic [c_vw-1:0] c_v_one     = c_vw'(1);
    localparam logic [3:0]      c_max_x     = 4'(COLS - 1);
    localparam logic [3:0]      c_max_y     = 4'(ROWS - 1);
    localparam logic [3:0]      c_start_x   = 4'(START_X);
    localparam logic [3:0]      c_start_y   = 4'(START_Y);
    localparam logic [8:0]      c_start_px  = 9'(START_X * CELL_PX);
    localparam logic [8:0]      c_start_py  = 9'(START_Y * CELL_PX);
    localparam logic [3:0]      c_goal_x    = 4'(GOAL_X);
    localparam logic [3:0]      c_goal_y    = 4'(GOAL_Y);
    localparam logic [8:0]      c_cell_px   = 9'(CELL_PX);

    localparam logic [1:0] c_dir_up    = 2'd0;
    localparam logic [1:0] c_dir_down  = 2'd1;
    localparam logic [1:0] c_dir_left  = 2'd2;
    localparam logic [1:0] c_dir_right = 2'd3;

    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1 || (COLS - 1) * CELL_PX >= 512) begin : g_param_check
        $error("player_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CHECK    = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_dir;
    logic [3:0] r_cell_x, r_cell_y, r_prev_x, r_prev_y;
    logic [8:0] r_pix_x, r_pix_y;
    logic       r_redraw, r_bump;

    logic [3:0] w_raw, w_rise;
    logic       w_press, w_rep, w_evt;
    logic [1:0] w_press_dir, w_rep_dir, w_evt_dir;

    assign w_raw = {btn_right, btn_left, btn_down, btn_up};

`ifdef PLAYER_CTRL_AUTOREPEAT_EN
    logic [3:0] w_level;
`endif

    // Index 0..3 = up, down, left, right
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        logic              r_s1, r_s2, r_lvl, r_lvl_d;
        logic [c_db_w-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_lvl   <= 1'b0;
                r_lvl_d <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_s1    <= w_raw[gi];
                r_s2    <= r_s1;
                r_lvl_d <= r_lvl;
                if (r_s2 == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_db_last) begin
                    r_lvl <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_rise[gi] = r_lvl & ~r_lvl_d;
`ifdef PLAYER_CTRL_AUTOREPEAT_EN
        assign w_level[gi] = r_lvl;
`endif
    end

    always_comb begin
        w_press     = |w_rise;
        w_press_dir = c_dir_right;
        if (w_rise[0])      w_press_dir = c_dir_up;
        else if (w_rise[1]) w_press_dir = c_dir_down;
        else if (w_rise[2]) w_press_dir = c_dir_left;
    end

`ifdef PLAYER_CTRL_AUTOREPEAT_EN
    localparam int               c_rep_w    = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [c_rep_w-1:0] c_rep_last = c_rep_w'(REPEAT_CYCLES - 1);

    logic               r_rep_active;
    logic [1:0]         r_rep_btn;
    logic [c_rep_w-1:0] r_rep_cnt;

    assign w_rep     = r_rep_active && w_level[r_rep_btn] && (r_rep_cnt == c_rep_last);
    assign w_rep_dir = r_rep_btn;

    // Tracks the button that won the last press; restarts on each new press
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_active <= 1'b0;
            r_rep_btn    <= c_dir_up;
            r_rep_cnt    <= '0;
        end else if (w_press) begin
            r_rep_active <= 1'b1;
            r_rep_btn    <= w_press_dir;
            r_rep_cnt    <= '0;
        end else if (r_rep_active && !w_level[r_rep_btn]) begin
            r_rep_active <= 1'b0;
            r_rep_cnt    <= '0;
        end else if (r_rep_active) begin
            r_rep_cnt <= (r_rep_cnt == c_rep_last) ? '0 : r_rep_cnt + 1'b1;
        end
    end
`else
    assign w_rep     = 1'b0;
    assign w_rep_dir = c_dir_up;
`endif

    assign w_evt     = w_press | w_rep;
    assign w_evt_dir = w_press ? w_press_dir : w_rep_dir;

    logic [3:0]      w_nx, w_ny;
    logic            w_edge, w_use_v, w_wall, w_blocked;
    int              w_idx;
    logic [c_hw-1:0] w_h_mask;
    logic [c_vw-1:0] w_v_mask;

    // Wall bit and border test for the latched direction from the current cell
    always_comb begin
        w_nx    = r_cell_x;
        w_ny    = r_cell_y;
        w_edge  = 1'b0;
        w_use_v = 1'b0;
        w_idx   = 0;
        case (r_dir)
            c_dir_up: begin
                w_edge = (r_cell_y == 4'd0);
                w_idx  = int'(r_cell_y) * COLS + int'(r_cell_x);
                w_ny   = r_cell_y - 4'd1;
            end
            c_dir_down: begin
                w_edge = (r_cell_y == c_max_y);
                w_idx  = (int'(r_cell_y) + 1) * COLS + int'(r_cell_x);
                w_ny   = r_cell_y + 4'd1;
            end
            c_dir_left: begin
                w_use_v = 1'b1;
                w_edge  = (r_cell_x == 4'd0);
                w_idx   = int'(r_cell_y) * (COLS + 1) + int'(r_cell_x);
                w_nx    = r_cell_x - 4'd1;
            end
            default: begin
                w_use_v = 1'b1;
                w_edge  = (r_cell_x == c_max_x);
                w_idx   = int'(r_cell_y) * (COLS + 1) + int'(r_cell_x) + 1;
                w_nx    = r_cell_x + 4'd1;
            end
        endcase
        w_h_mask  = c_h_one << w_idx;
        w_v_mask  = c_v_one << w_idx;
        w_wall    = w_use_v ? |(v_walls & w_v_mask) : |(h_walls & w_h_mask);
        w_blocked = w_edge | w_wall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_dir    <= c_dir_up;
            r_cell_x <= c_start_x;
            r_cell_y <= c_start_y;
            r_prev_x <= c_start_x;
            r_prev_y <= c_start_y;
            r_pix_x  <= c_start_px;
            r_pix_y  <= c_start_py;
            r_redraw <= 1'b0;
            r_bump   <= 1'b0;
        end else begin
            r_bump <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_evt) begin
                        r_dir   <= w_evt_dir;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_blocked) begin
                        r_bump  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_prev_x <= r_cell_x;
                        r_prev_y <= r_cell_y;
                        r_cell_x <= w_nx;
                        r_cell_y <= w_ny;
                        r_pix_x  <= {5'd0, w_nx} * c_cell_px;
                        r_pix_y  <= {5'd0, w_ny} * c_cell_px;
                        r_redraw <= 1'b1;
                        r_state  <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (redraw_ack) begin
                        r_redraw <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cell_x  = r_cell_x;
    assign cell_y  = r_cell_y;
    assign pix_x   = r_pix_x;
    assign pix_y   = r_pix_y;
    assign prev_x  = r_prev_x;
    assign prev_y  = r_prev_y;
    assign redraw  = r_redraw;
    assign bump    = r_bump;
    assign at_goal = (r_cell_x == c_goal_x) && (r_cell_y == c_goal_y);

endmodule
`default_nettype wire
